sram_port_arbiter: RTL and testbench

//  Shares the byte-enabled read/write port (port 1) of the dual-port sram between two masters:
//   - M0: CPU load/store unit.
//   - M1: DMA/boot loader.

---
 rtl/sram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for sram port 1 (M0 cpu, M1 dma) with bounded RMW lock and tagged read return.
// Grant is combinational; read data returns one cycle later. Define SRAM_ARB_STATS_EN for grant/stall counters.
`ifndef RAM_ADDR_BITS
`define RAM_ADDR_BITS 10
`endif

module sram_port_arbiter #(
  parameter int ADDR_BITS = `RAM_ADDR_BITS,
  parameter int LOCK_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [ADDR_BITS-1:0] m0_addr,
  input  logic [3:0]           m0_byteen,
  input  logic [31:0]          m0_wdata,
  input  logic                 m0_lock,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [ADDR_BITS-1:0] m1_addr,
  input  logic [3:0]           m1_byteen,
  input  logic [31:0]          m1_wdata,
  input  logic                 m1_lock,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [31:0]          m1_rdata,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [3:0]           sram_byteen,
  output logic [31:0]          sram_data,
  output logic                 sram_wren,
  input  logic [31:0]          sram_q,
  output logic [31:0]          cnt_gnt0,
  output logic [31:0]          cnt_gnt1,
  output logic [31:0]          cnt_stall
);

  typedef enum logic [1:0] {IDLE, LOCKED0, LOCKED1} lock_state_t;

  localparam logic [3:0] LOCK_CNT_MAX = 4'(LOCK_MAX);

  lock_state_t state, state_nxt;
  logic [3:0]  lock_cnt, lock_cnt_nxt;
  logic        rr_last;
  logic        gnt0, gnt1;
  logic        held;

  logic        tag_vld;
  logic        tag_id;
  logic [3:0]  tag_be;
  logic [31:0] rd_mask;
  logic [31:0] rd_word;

  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    held         = 1'b0;
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;

    case (state)
      LOCKED0: begin
        if (m0_req && m0_lock) begin
          held = 1'b1;
          if (lock_cnt == LOCK_CNT_MAX && m1_req) begin
            gnt1         = 1'b1;
            state_nxt    = IDLE;
            lock_cnt_nxt = 4'd0;
          end else begin
            gnt0 = 1'b1;
            if (lock_cnt != LOCK_CNT_MAX) lock_cnt_nxt = lock_cnt + 4'd1;
          end
        end
      end
      LOCKED1: begin
        if (m1_req && m1_lock) begin
          held = 1'b1;
          if (lock_cnt == LOCK_CNT_MAX && m0_req) begin
            gnt0         = 1'b1;
            state_nxt    = IDLE;
            lock_cnt_nxt = 4'd0;
          end else begin
            gnt1 = 1'b1;
            if (lock_cnt != LOCK_CNT_MAX) lock_cnt_nxt = lock_cnt + 4'd1;
          end
        end
      end
      default: ;
    endcase

    // A dropped lock falls straight into round-robin in the same cycle.
    if (!held) begin
      state_nxt    = IDLE;
      lock_cnt_nxt = 4'd0;
      if (m0_req && (!m1_req || rr_last)) gnt0 = 1'b1;
      else if (m1_req)                    gnt1 = 1'b1;
      if (gnt0 && m0_lock) begin
        state_nxt    = LOCKED0;
        lock_cnt_nxt = 4'd1;
      end else if (gnt1 && m1_lock) begin
        state_nxt    = LOCKED1;
        lock_cnt_nxt = 4'd1;
      end
    end

    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    sram_addr   = '0;
    sram_byteen = 4'h0;
    sram_data   = 32'h0;
    sram_wren   = 1'b0;
    if (gnt0) begin
      sram_addr   = m0_addr;
      sram_byteen = m0_byteen;
      sram_data   = m0_wdata;
      sram_wren   = m0_we;
    end else if (gnt1) begin
      sram_addr   = m1_addr;
      sram_byteen = m1_byteen;
      sram_data   = m1_wdata;
      sram_wren   = m1_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_cnt <= 4'd0;
      rr_last  <= 1'b1;
      tag_vld  <= 1'b0;
      tag_id   <= 1'b0;
      tag_be   <= 4'h0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      if (gnt0 || gnt1) rr_last <= gnt1;
      tag_vld <= (gnt0 && !m0_we) || (gnt1 && !m1_we);
      tag_id  <= gnt1;
      tag_be  <= sram_byteen;
    end
  end

  // Lanes not enabled on the read are forced to zero, so byteen=0 returns 0.
  assign rd_mask = {{8{tag_be[3]}}, {8{tag_be[2]}}, {8{tag_be[1]}}, {8{tag_be[0]}}};
  assign rd_word = sram_q & rd_mask;

  assign m0_rvalid = tag_vld && !tag_id;
  assign m1_rvalid = tag_vld && tag_id;
  assign m0_rdata  = m0_rvalid ? rd_word : 32'h0;
  assign m1_rdata  = m1_rvalid ? rd_word : 32'h0;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0  <= 32'h0;
      stat_gnt1  <= 32'h0;
      stat_stall <= 32'h0;
    end else begin
      if (gnt0) stat_gnt0 <= stat_gnt0 + 32'd1;
      if (gnt1) stat_gnt1 <= stat_gnt1 + 32'd1;
      if ((m0_req && !gnt0) || (m1_req && !gnt1)) stat_stall <= stat_stall + 32'd1;
    end
  end

  assign cnt_gnt0  = stat_gnt0;
  assign cnt_gnt1  = stat_gnt1;
  assign cnt_stall = stat_stall;
`else
  assign cnt_gnt0  = 32'h0;
  assign cnt_gnt1  = 32'h0;
  assign cnt_stall = 32'h0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-enabled registered-read sram model.
// Inputs are driven at the falling edge, outputs sampled 1 time unit later.
module tb_sram_port_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_byteen, m1_byteen;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_byteen;
  logic [31:0]   sram_data, sram_q;
  logic          sram_wren;
  logic [31:0]   cnt_gnt0, cnt_gnt1, cnt_stall;

  logic [31:0]   mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_BITS(AW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .sram_addr(sram_addr), .sram_byteen(sram_byteen), .sram_data(sram_data),
    .sram_wren(sram_wren), .sram_q(sram_q),
    .cnt_gnt0(cnt_gnt0), .cnt_gnt1(cnt_gnt1), .cnt_stall(cnt_stall)
  );

  always @(posedge clk) begin
    if (sram_wren) begin
      for (int b = 0; b < 4; b++)
        if (sram_byteen[b]) mem[sram_addr][b*8 +: 8] <= sram_data[b*8 +: 8];
    end
    sram_q <= mem[sram_addr];
  end

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_byteen = 4'h0; m0_wdata = 32'h0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_byteen = 4'h0; m1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    m0_req = 1; m1_req = 1; m0_byteen = 4'hF; m1_byteen = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got %b%b want 00", m0_gnt, m1_gnt);
    end
    n_tests++;
    if (sram_wren !== 1'b0 || sram_byteen !== 4'h0 || sram_addr !== '0) begin
      n_fail++; $display("FAIL reset_sram: wren=%b be=%h addr=%h want 0", sram_wren, sram_byteen, sram_addr);
    end
    n_tests++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd: rvalid=%b%b want 00", m0_rvalid, m1_rvalid);
    end
    n_tests++;
    if (cnt_gnt0 !== 32'h0 || cnt_gnt1 !== 32'h0 || cnt_stall !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0", cnt_gnt0, cnt_gnt1, cnt_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_first_gnt: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt);
    end
    clear_inputs();
  endtask

  task automatic test_alternation();
    logic exp0, prev0;
    do_reset();
    m0_req = 1; m0_addr = 10'h010; m0_byteen = 4'hF;
    m1_req = 1; m1_addr = 10'h020; m1_byteen = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp0 = (i % 2 == 0);
      n_tests++;
      if (m0_gnt !== exp0 || m1_gnt !== !exp0 || sram_addr !== (exp0 ? 10'h010 : 10'h020)) begin
        n_fail++; $display("FAIL alt_gnt[%0d]: m0=%b m1=%b addr=%h want m0=%b", i, m0_gnt, m1_gnt, sram_addr, exp0);
      end
      if (i > 0) begin
        prev0 = !exp0;
        n_tests++;
        if (m0_rvalid !== prev0 || m1_rvalid !== !prev0) begin
          n_fail++; $display("FAIL alt_rvalid[%0d]: got %b%b want m0=%b", i, m0_rvalid, m1_rvalid, prev0);
        end
        n_tests++;
        if ((prev0 ? m0_rdata : m1_rdata) !== (prev0 ? 32'hC0DE0010 : 32'hD0DE0020)) begin
          n_fail++; $display("FAIL alt_rdata[%0d]: got %h/%h", i, m0_rdata, m1_rdata);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    #1;
    n_tests++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hD0DE0020 || m0_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL alt_last: m1_rvalid=%b rdata=%h want 1 d0de0020", m1_rvalid, m1_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 10'h005; m1_byteen = 4'hF; m1_wdata = 32'hAABBCCDD;
    #1;
    n_tests++;
    if (m1_gnt !== 1'b1 || sram_wren !== 1'b1 || sram_byteen !== 4'hF || sram_data !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL bl_wr1: gnt=%b wren=%b be=%h data=%h", m1_gnt, sram_wren, sram_byteen, sram_data);
    end
    @(negedge clk);
    m1_wdata = 32'h11223344; m1_byteen = 4'b0101;
    #1;
    n_tests++;
    if (sram_wren !== 1'b1 || sram_byteen !== 4'b0101 || sram_data !== 32'h11223344) begin
      n_fail++; $display("FAIL bl_wr2: wren=%b be=%h data=%h", sram_wren, sram_byteen, sram_data);
    end
    @(negedge clk);
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_addr = 10'h005; m0_byteen = 4'hF;
    #1;
    n_tests++;
    if (m0_gnt !== 1'b1 || sram_wren !== 1'b0 || sram_addr !== 10'h005) begin
      n_fail++; $display("FAIL bl_rd_gnt: gnt=%b wren=%b addr=%h", m0_gnt, sram_wren, sram_addr);
    end
    @(negedge clk);
    m0_byteen = 4'b0011;
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hAA22CC44 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL bl_rd_full: rvalid=%b rdata=%h want 1 aa22cc44", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    m0_byteen = 4'h0;
    #1;
    n_tests++;
    if (m0_rdata !== 32'h0000CC44 || m0_gnt !== 1'b1 || sram_byteen !== 4'h0) begin
      n_fail++; $display("FAIL bl_rd_lo: rdata=%h gnt=%b be=%h want 0000cc44 1 0", m0_rdata, m0_gnt, sram_byteen);
    end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL bl_rd_be0: rvalid=%b rdata=%h want 1 0", m0_rvalid, m0_rdata);
    end
    n_tests++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || sram_byteen !== 4'h0 || sram_wren !== 1'b0) begin
      n_fail++; $display("FAIL bl_idle: gnt=%b%b be=%h wren=%b", m0_gnt, m1_gnt, sram_byteen, sram_wren);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL bl_drain: rvalid=%b rdata=%h want 0 0", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_lock_bound();
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 10'h001; m0_byteen = 4'hF;
    m1_req = 1; m1_addr = 10'h002; m1_byteen = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (m0_gnt !== (i < 4) || m1_gnt !== (i == 4)) begin
        n_fail++; $display("FAIL lock_cyc[%0d]: m0=%b m1=%b want m0=%b m1=%b", i, m0_gnt, m1_gnt, i < 4, i == 4);
      end
      @(negedge clk);
    end
    m0_lock = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (m0_gnt !== (i != 1) || m1_gnt !== (i == 1)) begin
        n_fail++; $display("FAIL lock_rr[%0d]: m0=%b m1=%b want m0=%b", i, m0_gnt, m1_gnt, i != 1);
      end
      @(negedge clk);
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    m0_req = 1; m0_addr = 10'h010; m0_byteen = 4'hF;
    #1;
    n_tests++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_gnt: got %b want 1", m0_gnt);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (m0_gnt !== 1'b0 || sram_addr !== '0 || sram_byteen !== 4'h0) begin
      n_fail++; $display("FAIL mid_async_gnt: gnt=%b addr=%h be=%h want 0", m0_gnt, sram_addr, sram_byteen);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_rvalid_dropped: rvalid=%b rdata=%h want 0", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hC0DE0010) begin
      n_fail++; $display("FAIL mid_rvalid_set: rvalid=%b rdata=%h want 1 c0de0010", m0_rvalid, m0_rdata);
    end
    m0_req = 0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_async_clear: rvalid=%b rdata=%h want 0", m0_rvalid, m0_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_stats();
    logic [31:0] e0, e1, es;
`ifdef SRAM_ARB_STATS_EN
    e0 = 32'd5; e1 = 32'd5; es = 32'd10;
`else
    e0 = 32'd0; e1 = 32'd0; es = 32'd0;
`endif
    do_reset();
    m0_req = 1; m0_addr = 10'h010; m0_byteen = 4'hF;
    m1_req = 1; m1_addr = 10'h020; m1_byteen = 4'hF;
    repeat (10) @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (cnt_gnt0 !== e0 || cnt_gnt1 !== e1) begin
      n_fail++; $display("FAIL stats_gnt: got %0d %0d want %0d %0d", cnt_gnt0, cnt_gnt1, e0, e1);
    end
    n_tests++;
    if (cnt_stall !== es) begin
      n_fail++; $display("FAIL stats_stall: got %0d want %0d", cnt_stall, es);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h0;
    mem[10'h010] = 32'hC0DE0010;
    mem[10'h020] = 32'hD0DE0020;
    sram_q = 32'h0;
    test_reset();
    test_alternation();
    test_byte_lanes();
    test_lock_bound();
    test_reset_mid_read();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1);
  end

endmodule
